// File: rtl/hamming_encoder.sv
// Hamming (16,11) SECDED encoder engine: reads 11-bit messages as byte pairs and writes 16-bit codewords back.
// Optional macro HAMMING_ERR_INJECT_EN adds inj_pos to flip one codeword bit for decoder stimulus.
module hamming_encoder #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 64,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic [7:0]    mem_rd_data,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic [4:0]    inj_pos,
`endif
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [6:0]    LAST_IDX = 7'(NUM_MSG - 1);
  localparam logic [AW-1:0] SRC_ADDR = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_ADDR = AW'(DST_BASE);

  state_t      state_reg;
  logic [6:0]  idx_reg;
  logic [15:0] cw_reg;
  logic [7:0]  lo_reg;
  logic        done_reg;

  logic [AW-1:0] idx_off;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [15:0]   cw_clean;
  logic [15:0]   cw_next;

  // d[k] lives at bit k-1 of the 11-bit message vector.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic p8, p4, p2, p1;
    logic [15:0] c;
    p8 = ^d[10:4];
    p4 = (^d[10:7]) ^ (^d[3:1]);
    p2 = d[10] ^ d[9] ^ d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0];
    p1 = d[10] ^ d[8] ^ d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];
    c  = {d[10:4], p8, d[3:1], p4, d[0], p2, p1, 1'b0};
    c[0] = ^c[15:1];
    return c;
  endfunction

  assign idx_off  = AW'({idx_reg, 1'b0});
  assign src_addr = SRC_ADDR + idx_off;
  assign dst_addr = DST_ADDR + idx_off;
  assign cw_clean = encode({mem_rd_data[2:0], lo_reg});

`ifdef HAMMING_ERR_INJECT_EN
  logic [15:0] inj_mask;

  // Positions 16..31 match no bit, leaving the codeword clean.
  for (genvar gi = 0; gi < 16; gi++) begin : g_inj_mask
    assign inj_mask[gi] = (inj_pos == 5'(gi));
  end

  assign cw_next = cw_clean ^ inj_mask;
`else
  assign cw_next = cw_clean;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      cw_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (init) begin
            idx_reg   <= '0;
            done_reg  <= 1'b0;
            state_reg <= RD_LO;
          end
        end
        RD_LO: begin
          lo_reg    <= mem_rd_data;
          state_reg <= RD_HI;
        end
        RD_HI: begin
          cw_reg    <= cw_next;
          state_reg <= WR_LO;
        end
        WR_LO: begin
          state_reg <= WR_HI;
        end
        WR_HI: begin
          if (idx_reg == LAST_IDX) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg   <= idx_reg + 7'd1;
            state_reg <= RD_LO;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state_reg)
      RD_LO: mem_addr = src_addr;
      RD_HI: mem_addr = src_addr + AW'(1);
      WR_LO: begin
        mem_addr    = dst_addr;
        mem_wr_en   = 1'b1;
        mem_wr_data = cw_reg[7:0];
      end
      WR_HI: begin
        mem_addr    = dst_addr + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = cw_reg[15:8];
      end
      default: begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
      end
    endcase
  end

  assign done = done_reg;

endmodule

// File: tb/tb_hamming_encoder.sv
// Directed bench for hamming_encoder: byte-wide memory model, hand-computed codewords, run timing and reset cases.
module tb_hamming_encoder;

  localparam int NUM_MSG = 15;
  localparam int DST     = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init;
  logic [7:0] mem_rd_data;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       done;
  logic [4:0] inj_pos;

  logic [7:0]  mem [256];
  logic        tb_we;
  logic [7:0]  tb_addr;
  logic [7:0]  tb_data;
  int          wr_count = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] src_w  [NUM_MSG];
  logic [15:0] exp_cw [NUM_MSG];

  always #5 clk = ~clk;

  hamming_encoder #(
    .NUM_MSG (NUM_MSG),
    .SRC_BASE(0),
    .DST_BASE(DST),
    .AW      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .mem_rd_data(mem_rd_data),
`ifdef HAMMING_ERR_INJECT_EN
    .inj_pos    (inj_pos),
`endif
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_data(mem_wr_data),
    .done       (done)
  );

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_count      <= wr_count + 1;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic poke(input int addr, input logic [7:0] data);
    tb_addr = 8'(addr);
    tb_data = data;
    tb_we   = 1'b1;
    @(posedge clk);
    #1;
    tb_we = 1'b0;
  endtask

  task automatic load_src();
    for (int i = 0; i < NUM_MSG; i++) begin
      poke(2 * i, src_w[i][7:0]);
      poke(2 * i + 1, src_w[i][15:8]);
    end
  endtask

  task automatic fill_dst(input logic [7:0] val);
    for (int i = 0; i < 2 * NUM_MSG; i++) poke(DST + i, val);
  endtask

  task automatic check_dst(input logic [15:0] mask);
    for (int i = 0; i < NUM_MSG; i++) begin
      check($sformatf("cw%0d_lo", i), 32'(mem[DST + 2 * i]), 32'(exp_cw[i][7:0] ^ mask[7:0]));
      check($sformatf("cw%0d_hi", i), 32'(mem[DST + 2 * i + 1]), 32'(exp_cw[i][15:8] ^ mask[15:8]));
    end
  endtask

  // Starts a run, optionally pulses init again at cycle pulse_at, and times done.
  task automatic run(input string name, input int pulse_at);
    int lat;
    int start_wr;
    init = 1'b1;
    @(posedge clk);
    #1;
    init     = 1'b0;
    start_wr = wr_count;
    check({name, "_done_clr"}, 32'(done), 32'd0);
    lat = 0;
    while (!done && lat < 300) begin
      init = (lat == pulse_at);
      @(posedge clk);
      #1;
      lat++;
    end
    init = 1'b0;
    check({name, "_done_lat"}, 32'(lat), 32'd60);
    check({name, "_wr_count"}, 32'(wr_count - start_wr), 32'd30);
    check({name, "_idle_addr"}, 32'(mem_addr), 32'd0);
    check({name, "_idle_wr_en"}, 32'(mem_wr_en), 32'd0);
    $display("run %s: latency=%0d writes=%0d", name, lat, wr_count - start_wr);
  endtask

  initial begin
    int pulses;
    bit found;
    rst_n   = 1'b0;
    init    = 1'b0;
    tb_we   = 1'b0;
    tb_addr = '0;
    tb_data = '0;
    inj_pos = 5'd31;

    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wr_data", 32'(mem_wr_data), 32'd0);
    rst_n = 1'b1;

    // All-ones messages
    for (int i = 0; i < NUM_MSG; i++) begin
      src_w[i]  = 16'h07FF;
      exp_cw[i] = 16'hFFFF;
    end
    load_src();
    fill_dst(8'h00);
    run("ones", -1);
    check_dst(16'h0000);

    // Single data bits, zero, ignored high bits, a two-bit pattern, all bits set
    src_w  = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080,
               16'h0100, 16'h0200, 16'h0400, 16'h0000, 16'hF800, 16'h0003, 16'hFFFF};
    exp_cw = '{16'h000F, 16'h0033, 16'h0055, 16'h0096, 16'h0303, 16'h0505, 16'h0906, 16'h1111,
               16'h2112, 16'h4114, 16'h8117, 16'h0000, 16'h0000, 16'h003C, 16'hFFFF};
    load_src();
    run("midinit", 20);
    check_dst(16'h0000);

    // Restart from DONE after clearing the destination
    fill_dst(8'h00);
    run("rerun", -1);
    check_dst(16'h0000);

    // init held high: one done cycle per run
    init   = 1'b1;
    pulses = 0;
    for (int c = 0; c < 125; c++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    init = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd2);
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk);
      #1;
    end
    check("b2b_finish", 32'(done), 32'd1);
    $display("run b2b: done_pulses=%0d", pulses);

    // Reset asserted during WR_HI of message 3
    fill_dst(8'h5A);
    init = 1'b1;
    @(posedge clk);
    #1;
    init  = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk);
      #1;
      if (mem_wr_en && mem_addr == 8'(DST + 7)) found = 1'b1;
    end
    check("wrhi3_seen", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_wr_data", 32'(mem_wr_data), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_lo3", 32'(mem[DST + 6]), 32'h96);
    check("mid_rst_hi3", 32'(mem[DST + 7]), 32'h5A);
    check("mid_rst_lo4", 32'(mem[DST + 8]), 32'h5A);
    check("mid_rst_idle_done", 32'(done), 32'd0);
    $display("run midrst: lo3=%0h hi3=%0h", mem[DST + 6], mem[DST + 7]);
    rst_n = 1'b1;
    run("after_rst", -1);
    check_dst(16'h0000);

`ifdef HAMMING_ERR_INJECT_EN
    inj_pos = 5'd5;
    run("inj5", -1);
    check_dst(16'h0020);
    inj_pos = 5'd20;
    run("inj20", -1);
    check_dst(16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
